// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from the IO-side byte FIFO and serializes each one
// as an 8N1 / 8N2 UART frame on serial_out (idle high, LSB first).
module uart_fifo_tx #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rd_en,
   output logic       serial_out,
   output logic       busy
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             ser_q, ser_d;

   logic             bit_done;
   logic [CNT_W-1:0] cnt_inc;

   // Bit boundary: last cycle of the current symbol; the counter then wraps.
   assign bit_done = (cnt_q == CNT_W'(SYMBOL_EDGE_TIME - 1));
   assign cnt_inc  = bit_done ? '0 : cnt_q + CNT_W'(1);

   // Next-state, datapath updates and the combinational pop strobe.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      ser_d      = ser_q;
      fifo_rd_en = 1'b0;

      case (state_q)
         IDLE: begin
            ser_d = 1'b1;
            cnt_d = '0;
            idx_d = '0;
            if (enable && !fifo_empty) begin
               fifo_rd_en = 1'b1;
               state_d    = LOAD;
            end
         end
         // FIFO read data is registered, so it becomes valid here, one cycle
         // after the pop; the start bit is launched at the same edge.
         LOAD: begin
            shift_d = fifo_dout;
            ser_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = START;
         end
         START: begin
            cnt_d = cnt_inc;
            if (bit_done) begin
               ser_d   = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_inc;
            if (bit_done) begin
               // Index wraps 7 -> 0, which also seeds the stop-bit count.
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  ser_d   = 1'b1;
                  state_d = STOP;
               end else begin
                  ser_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         STOP: begin
            cnt_d = cnt_inc;
            if (bit_done) begin
               if (idx_q == 3'(STOP_BITS - 1)) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Never pop while the block is being reset.
      if (rst) begin
         fifo_rd_en = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset; a reset mid-frame
   // drops the popped byte and returns the line to idle on the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         ser_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         ser_q   <= ser_d;
      end
   end

   assign serial_out = ser_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx. Two instances share clk/rst/enable:
// index 0 uses one stop bit, index 1 uses two. SYMBOL_EDGE_TIME = 10.
module tb_uart_fifo_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [1:0] fe;
   logic [1:0] rd;
   logic [1:0] ser;
   logic [1:0] bsy;
   logic [7:0] dout [2];

   // Simple FIFO models, one per instance.
   logic [7:0] mem [2][16];
   int         wp [2];
   int         rp [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_fifo_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(1)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fe[0]),
      .fifo_dout (dout[0]),
      .fifo_rd_en(rd[0]),
      .serial_out(ser[0]),
      .busy      (bsy[0])
   );

   uart_fifo_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .fifo_empty(fe[1]),
      .fifo_dout (dout[1]),
      .fifo_rd_en(rd[1]),
      .serial_out(ser[1]),
      .busy      (bsy[1])
   );

   assign fe[0] = (wp[0] == rp[0]);
   assign fe[1] = (wp[1] == rp[1]);

   // Registered FIFO read port: data appears the cycle after the pop.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rd[i] && !fe[i]) begin
            dout[i] <= mem[i][rp[i] % 16];
            rp[i]   <= rp[i] + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int d, input logic [7:0] b);
      mem[d][wp[d] % 16] = b;
      wp[d]++;
   endtask

   // The current cycle is the pop cycle T. Steps through the whole frame and
   // ends at the first IDLE cycle, where a pop is expected iff next_pop.
   // drop_at >= 0 deasserts enable during cycle T+drop_at.
   task automatic run_frame(input int d, input logic [7:0] b, input int stops,
                            input logic next_pop, input int drop_at, input string name);
      int   last;
      logic exp_ser;
      last = 101 + 10 * (stops - 1);
      #1;
      check($sformatf("%s pop T", name), rd[d], 1'b1);
      for (int k = 1; k <= last + 1; k++) begin
         tick();
         if (k < 2)       exp_ser = 1'b1;
         else if (k < 12) exp_ser = 1'b0;
         else if (k < 92) exp_ser = b[(k - 12) / 10];
         else             exp_ser = 1'b1;
         check($sformatf("%s ser T+%0d", name, k), ser[d], exp_ser);
         check($sformatf("%s busy T+%0d", name, k), bsy[d], k <= last);
         check($sformatf("%s rd T+%0d", name, k), rd[d], (k == last + 1) ? next_pop : 1'b0);
         if (k == drop_at) enable = 1'b0;
      end
   endtask

   initial begin
      wp[0] = 0; wp[1] = 0; rp[0] = 0; rp[1] = 0;
      dout[0] = '0; dout[1] = '0;
      rst    = 1'b1;
      enable = 1'b0;

      // 1. Reset and idle with an empty FIFO.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst ser", ser[0], 1'b1);
         check("rst busy", bsy[0], 1'b0);
         check("rst rd", rd[0], 1'b0);
      end
      rst    = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle ser", ser[0], 1'b1);
         check("idle busy", bsy[0], 1'b0);
         check("idle rd", rd[0], 1'b0);
         check("idle ser2", ser[1], 1'b1);
      end

      // 2. Single byte 0xA5.
      push(0, 8'hA5);
      run_frame(0, 8'hA5, 1, 1'b0, -1, "a5");

      // 3. Back-to-back 0x00 then 0xFF; second pop at T+102.
      push(0, 8'h00);
      push(0, 8'hFF);
      run_frame(0, 8'h00, 1, 1'b1, -1, "b2b00");
      run_frame(0, 8'hFF, 1, 1'b0, -1, "b2bff");

      // 4a. enable low with a non-empty FIFO: nothing happens.
      enable = 1'b0;
      push(0, 8'h55);
      push(0, 8'h81);
      for (int i = 0; i < 200; i++) begin
         tick();
         check("gate rd", rd[0], 1'b0);
         check("gate ser", ser[0], 1'b1);
      end
      // 4b. enable dropped mid-frame: frame completes, no pop at T+102.
      enable = 1'b1;
      run_frame(0, 8'h55, 1, 1'b0, 40, "drop");
      for (int i = 0; i < 5; i++) begin
         tick();
         check("drop hold rd", rd[0], 1'b0);
      end
      enable = 1'b1;
      run_frame(0, 8'h81, 1, 1'b0, -1, "resume");

      // 5. Two stop bits: stop lasts 20 cycles, next pop at T+112.
      push(1, 8'h3C);
      push(1, 8'h96);
      run_frame(1, 8'h3C, 2, 1'b1, -1, "stop2a");
      run_frame(1, 8'h96, 2, 1'b0, -1, "stop2b");

      // 6. Reset during DATA bit 3 of 0xC3; 0xC3 is discarded, 0x5A follows.
      push(0, 8'hC3);
      push(0, 8'h5A);
      #1;
      check("rstmid pop", rd[0], 1'b1);
      for (int k = 1; k <= 45; k++) tick();
      check("rstmid bit3", ser[0], 1'b0);
      check("rstmid busy", bsy[0], 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rstmid ser", ser[0], 1'b1);
         check("rstmid busy0", bsy[0], 1'b0);
         check("rstmid rd", rd[0], 1'b0);
      end
      rst = 1'b0;
      run_frame(0, 8'h5A, 1, 1'b0, -1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- Serial transmit stage that sits directly downstream of the IO-side byte FIFO.
- Pops bytes from the FIFO read port and serializes each one as an 8N1 (or 8N2) UART frame on serial_out.
- Lets the CPU-side MMIO logic queue bytes without waiting on the line rate.

Parameters:
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.
- Derived localparam SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer division, in cycles per bit.
- Derived baud counter width = $clog2(SYMBOL_EDGE_TIME).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  permits starting new frames.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; registered in the FIFO, valid the cycle after the rd_en cycle.
- fifo_rd_en  output  1  FIFO pop strobe.
- serial_out  output  1  UART TX line, idle high.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: serial_out=1, busy=0, fifo_rd_en=0, state=IDLE, counters=0.
- While rst is high, fifo_rd_en is forced to 0.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE: fifo_rd_en = enable & !fifo_empty. This is combinational, so the pop is one cycle exactly. When it is 1, go to LOAD. Otherwise hold, with serial_out=1.
- LOAD (1 cycle): capture fifo_dout into the shift register, drive serial_out<=0, clear the baud counter, go to START.
- fifo_rd_en is never asserted outside IDLE, and never while fifo_empty=1.
- START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA with serial_out<=bit0.
- DATA: 8 bits, LSB first, each held SYMBOL_EDGE_TIME cycles. A 3-bit index counts 0..7; after bit 7 expires, go to STOP with serial_out<=1.
- STOP: serial_out=1 for STOP_BITS*SYMBOL_EDGE_TIME cycles, then go to IDLE.
- serial_out is a register output; there is no combinational path to the line.
- Frame occupancy is (10 or 11)*SYMBOL_EDGE_TIME cycles of line time.
- Pop-to-pop spacing for back-to-back bytes is exactly 1 (LOAD) + frame + 1 (IDLE) cycles.
- Baud counter counts 0..SYMBOL_EDGE_TIME-1. A bit boundary occurs when it equals SYMBOL_EDGE_TIME-1; the counter then wraps to 0.
- enable deasserted mid-frame: the current frame completes unchanged; the next IDLE does not pop.
- enable or fifo_empty changing in LOAD/START/DATA/STOP: ignored.
- Reset mid-frame:
  - Next edge gives serial_out=1 and state IDLE.
  - The popped byte is discarded; no retransmit.
  - After rst falls, transmission resumes from the next FIFO entry.
- FIFO assumed to hold data stable until the next pop. The FIFO ignores rd_en when empty; this block also never issues one.

Test Plan:
(All with CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10.)
1. Reset idle: rst high 5 cycles, then fifo_empty=1, enable=1 for 50 cycles -> serial_out=1, busy=0, fifo_rd_en=0 throughout.
2. Single byte 0xA5, STOP_BITS=1:
   - fifo_rd_en pulses 1 cycle at T; fifo_dout=0xA5 at T+1.
   - serial_out: low T+2..T+11; then bits 1,0,1,0,0,1,0,1, each 10 cycles; then high 10 cycles.
   - busy high T+1..T+101, low at T+102.
3. Back-to-back 0x00 then 0xFF, FIFO non-empty -> rd_en pulses at T and T+102. 0x00 frame shows line low for 90 cycles; 0xFF frame shows low only for the 10-cycle start bit.
4. enable gating:
   - enable=0 with FIFO non-empty for 200 cycles -> no rd_en, serial_out=1.
   - enable dropped at T+40 of a frame -> that frame finishes at T+101; no pop at T+102.
5. STOP_BITS=2, byte 0x3C -> stop high 20 cycles; next pop at T+112.
6. rst asserted during DATA bit 3 for 2 cycles:
   - serial_out=1 and busy=0 from the next edge; fifo_rd_en=0 during rst.
   - After release with FIFO non-empty, a pop occurs in the first post-reset cycle and a full clean frame follows.
